serial_bit_deserializer: RTL and testbench

Sequential receive-side counterpart of the team's combinational bit-order reverser: accepts one serial bit per valid cycle, assembles WIDTH-bit words and presents them on a valid/ready output with a one-entry holding register. Bit order is configurable at compile time, so the block delivers words already in the order downstream parallel logic expects. Sits between a serial front end and byte-wide consumers in simulation and FPGA designs.

---
 rtl/serial_deser_pkg.sv | 21 ++
 rtl/deser_out_reg.sv | 57 +++++
 rtl/serial_bit_deserializer.sv | 110 +++++++++++
 tb/tb_serial_bit_deserializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_deser_pkg.sv
// rtl/serial_deser_pkg.sv - shared types and helpers for the serial bit deserializer
//
// Purpose: FSM state encoding, default word width and the bit counter
// width helper used by serial_bit_deserializer and its testbench.
// Ports: none (package).

package serial_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    // Width of a counter that holds 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// rtl/deser_out_reg.sv - one-entry valid/ready holding register with overrun detection
//
// Purpose: captures completed words from the assembler and holds them until
// the consumer takes them. A word arriving while a held word is still
// unconsumed (and not being consumed this cycle) is dropped and flagged.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load, load_data   completed word strobe and its value
//   data, valid       held word and its valid flag
//   ready             consumer accepts data when valid=1
//   overrun           sticky drop flag
//   overrun_clr       clears overrun (a simultaneous drop wins)

module deser_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    logic accept;
    logic drop;

    // The slot is free if empty or being emptied this very cycle.
    assign accept = load & (~valid | ready);
    assign drop   = load & valid & ~ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (accept) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_bit_deserializer.sv
// rtl/serial_bit_deserializer.sv - serial-to-parallel word assembler with valid/ready output
//
// Purpose: accepts one bit per bit_valid cycle, assembles WIDTH-bit words and
// hands them to a one-entry holding register (deser_out_reg).
// Build option: define BIT_REVERSE_EN for LSB-first assembly (first received
// bit lands in bit 0); otherwise MSB-first (first received bit in WIDTH-1).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   bit_in, bit_valid         serial bit and its qualifier
//   frame_start               drop any partial word; with bit_valid, bit_in is bit 0 of a new word
//   word_out, word_valid      assembled word and valid flag
//   word_ready                consumer handshake
//   overrun, overrun_clr      sticky drop flag and its clear
//   bit_count                 bits held in the current partial word

module serial_bit_deserializer
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          frame_start,
    output logic [WIDTH-1:0]              word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic [cnt_width(WIDTH)-1:0]   bit_count
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    deser_state_t     state, state_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    base_cnt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] base_sh;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_count <= '0;
            shreg     <= '0;
        end else begin
            state     <= state_nxt;
            bit_count <= cnt_nxt;
            shreg     <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_count;
        shreg_nxt = shreg;
        complete  = 1'b0;

        // A frame start (or having nothing held) means this bit starts from empty.
        if (frame_start || state == IDLE) begin
            base_cnt = '0;
            base_sh  = '0;
        end else begin
            base_cnt = bit_count;
            base_sh  = shreg;
        end

`ifdef BIT_REVERSE_EN
        shifted = {bit_in, base_sh[WIDTH-1:1]};
`else
        shifted = {base_sh[WIDTH-2:0], bit_in};
`endif

        if (bit_valid) begin
            if (base_cnt == LAST_CNT) begin
                complete  = 1'b1;
                cnt_nxt   = '0;
                shreg_nxt = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt   = base_cnt + 1'b1;
                shreg_nxt = shifted;
                state_nxt = SHIFT;
            end
        end else if (frame_start) begin
            cnt_nxt   = '0;
            shreg_nxt = '0;
            state_nxt = IDLE;
        end
    end

    deser_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (complete),
        .load_data  (shifted),
        .data       (word_out),
        .valid      (word_valid),
        .ready      (word_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

endmodule

// File: tb/tb_serial_bit_deserializer.sv
// tb/tb_serial_bit_deserializer.sv - self-checking bench for serial_bit_deserializer

module tb_serial_bit_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         word_ready = 1'b0;
    logic         overrun_clr = 1'b0;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         overrun;
    logic [2:0]   bit_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state for the random phase
    int           m_cnt;
    logic [7:0]   m_acc;
    logic         m_valid;
    logic [7:0]   m_data;
    logic         m_ovr;
    int           m_words;

    serial_bit_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .frame_start(frame_start),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word expected for a stream sent MSB-of-v first.
    function automatic logic [7:0] order(input logic [7:0] v);
        logic [7:0] r;
`ifdef BIT_REVERSE_EN
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
`else
        r = v;
`endif
        return r;
    endfunction

    task automatic drive(input logic bv, input logic b, input logic fs, input logic rdy, input logic clr);
        bit_valid   = bv;
        bit_in      = b;
        frame_start = fs;
        word_ready  = rdy;
        overrun_clr = clr;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] v, input logic rdy);
        for (int i = 7; i >= 0; i--) drive(1'b1, v[i], 1'b0, rdy, 1'b0);
    endtask

    task automatic tick(input logic bv, input logic b);
        logic rdy, clr, comp;
        logic [7:0] nw;
        rdy  = 1'($urandom_range(0, 1));
        clr  = ($urandom_range(0, 7) == 0);
        comp = 1'b0;
        nw   = '0;
        if (bv) begin
            m_acc = {m_acc[6:0], b};
            m_cnt++;
            if (m_cnt == 8) begin
                comp  = 1'b1;
                nw    = order(m_acc);
                m_cnt = 0;
                m_words++;
            end
        end
        if (comp && m_valid && !rdy) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (comp && (!m_valid || rdy)) begin
            m_data  = nw;
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        drive(bv, b, 1'b0, rdy, clr);
        check("rnd_valid", 32'(word_valid), 32'(m_valid));
        check("rnd_overrun", 32'(overrun), 32'(m_ovr));
        check("rnd_count", 32'(bit_count), 32'(m_cnt));
        if (m_valid) check("rnd_word", 32'(word_out), 32'(m_data));
    endtask

    initial begin
        logic [7:0] pat;

        // reset state
        #12;
        check("rst_word", 32'(word_out), 32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_count", 32'(bit_count), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic word 1,0,1,1,0,0,1,0
        pat = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, pat[i], 1'b0, 1'b1, 1'b0);
            if (i == 1) begin
                check("b2_count7", 32'(bit_count), 32'd7);
                check("b2_not_yet", 32'(word_valid), 32'h0);
            end
        end
        check("b2_valid", 32'(word_valid), 32'h1);
`ifdef BIT_REVERSE_EN
        check("b2_word", 32'(word_out), 32'h4D);
`else
        check("b2_word", 32'(word_out), 32'hB2);
`endif
        check("b2_count0", 32'(bit_count), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2_one_cycle", 32'(word_valid), 32'h0);

        // overrun with consumer stalled
        send_word(8'hA5, 1'b0);
        check("a5_valid", 32'(word_valid), 32'h1);
        check("a5_word", 32'(word_out), 32'(order(8'hA5)));
        check("a5_no_ovr", 32'(overrun), 32'h0);
        send_word(8'h3C, 1'b0);
        check("ovr_hold_word", 32'(word_out), 32'(order(8'hA5)));
        check("ovr_set", 32'(overrun), 32'h1);
        check("ovr_hold_valid", 32'(word_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ovr_clr", 32'(overrun), 32'h0);
        check("ovr_valid_fall", 32'(word_valid), 32'h0);

        // frame_start discards a partial word
        for (int i = 0; i < 5; i++) drive(1'b1, 1'(i % 2 == 0), 1'b0, 1'b1, 1'b0);
        check("fs_partial", 32'(bit_count), 32'd5);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("fs_count1", 32'(bit_count), 32'd1);
        check("fs_no_emit", 32'(word_valid), 32'h0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            if (i < 6) check("fs_no_early", 32'(word_valid), 32'h0);
        end
        check("fs_valid", 32'(word_valid), 32'h1);
        check("fs_word", 32'(word_out), 32'hFF);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("fs_alone_count", 32'(bit_count), 32'h0);
        check("fs_alone_valid", 32'(word_valid), 32'h0);

        // asynchronous reset mid-word
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("mid_count4", 32'(bit_count), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("arst_mid_count", 32'(bit_count), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // asynchronous reset with a held word and overrun
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        check("pre_rst_valid", 32'(word_valid), 32'h1);
        check("pre_rst_ovr", 32'(overrun), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(word_valid), 32'h0);
        check("arst_word", 32'(word_out), 32'h0);
        check("arst_ovr", 32'(overrun), 32'h0);
        check("arst_count", 32'(bit_count), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_word(8'h96, 1'b1);
        check("post_rst_valid", 32'(word_valid), 32'h1);
`ifdef BIT_REVERSE_EN
        check("post_rst_word", 32'(word_out), 32'h69);
`else
        check("post_rst_word", 32'(word_out), 32'h96);
`endif

        // random gaps and handshake against the model
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0; m_acc = '0; m_valid = 1'b0; m_data = '0; m_ovr = 1'b0; m_words = 0;
        while (m_words < 100) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick(1'b0, 1'b0);
            tick(1'b1, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
